// File: rtl/regfile_pkg.sv
// Shared types and helpers for the register-file read port.
package regfile_pkg;

  // Default architectural geometry; instances may override through parameters.
  localparam int unsigned DefNregs = 32;
  localparam int unsigned DefWidth = 64;
  localparam int unsigned AW       = $clog2(DefNregs);

  // XZR: reads as zero and is never bypassed.
  localparam logic [AW-1:0] XZR = 5'd31;

  typedef logic [DefWidth-1:0] word_t;

  typedef enum logic [1:0] {
    SelHold,
    SelZero,
    SelBypass,
    SelRegs
  } rd_sel_e;

  // Per-port source priority: no request holds, XZR beats bypass, bypass beats storage.
  function automatic rd_sel_e zero_or_bypass(input logic req, input logic is_zero,
                                             input logic hit);
    rd_sel_e sel;
    if (!req) begin
      sel = SelHold;
    end else if (is_zero) begin
      sel = SelZero;
    end else if (hit) begin
      sel = SelBypass;
    end else begin
      sel = SelRegs;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_read_port_word_mux_n.sv
// Combinational N:1 word mux built as a log2(N)-deep tree of 2:1 stages.
module word_mux_n #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 32
) (
  input  logic [N*WIDTH-1:0]     i_data,
  input  logic [$clog2(N)-1:0]   i_sel,
  output logic [WIDTH-1:0]       o_data
);

  localparam int unsigned Levels = $clog2(N);

  // Level l halves the candidate set using select bit l (LSB resolves adjacent pairs).
  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    localparam int unsigned Cnt = N >> (l + 1);
    logic [2*Cnt*WIDTH-1:0] w_in;
    logic [Cnt*WIDTH-1:0]   w_nodes;

    if (l == 0) begin : g_leaf
      assign w_in = i_data;
    end else begin : g_inner
      assign w_in = g_lvl[l-1].w_nodes;
    end

    for (genvar j = 0; j < Cnt; j++) begin : g_node
      assign w_nodes[j*WIDTH +: WIDTH] = i_sel[l] ? w_in[(2*j+1)*WIDTH +: WIDTH]
                                                  : w_in[(2*j)*WIDTH +: WIDTH];
    end
  end

  assign o_data = g_lvl[Levels-1].w_nodes;

endmodule

// File: rtl/regfile_read_port.sv
// Registered multi-port word read with same-cycle write bypass and zero register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NPORTS   = 2,
  parameter int unsigned ZERO_REG = 32'(XZR)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NREGS*WIDTH-1:0]            regs,
  input  logic [NPORTS-1:0]                 rd_req,
  input  logic [NPORTS*$clog2(NREGS)-1:0]   rd_addr,
  input  logic                              stall,
  input  logic                              wr_en,
  input  logic [$clog2(NREGS)-1:0]          wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
  output logic [NPORTS*WIDTH-1:0]           rd_data,
  output logic [NPORTS-1:0]                 rd_valid
);

  localparam int unsigned AddrW = $clog2(NREGS);
  localparam logic [AddrW-1:0] ZeroIdx = AddrW'(ZERO_REG);

  // A non-power-of-two file would let an index address past the storage image.
  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
    $error("regfile_read_port: NREGS must be a power of two and at least 2");
  end
  if (ZERO_REG >= NREGS) begin : g_bad_zero
    $error("regfile_read_port: ZERO_REG must index an existing register");
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [AddrW-1:0] w_addr;
    logic [WIDTH-1:0] w_mux_data;
    logic [WIDTH-1:0] w_next;
    logic             w_hit;
    logic             w_is_zero;
    rd_sel_e          w_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    assign w_addr = rd_addr[p*AddrW +: AddrW];

    word_mux_n #(
      .WIDTH (WIDTH),
      .N     (NREGS)
    ) u_mux (
      .i_data (regs),
      .i_sel  (w_addr),
      .o_data (w_mux_data)
    );

    assign w_is_zero = (w_addr == ZeroIdx);
    assign w_hit     = wr_en && (wr_addr == w_addr);
    assign w_sel     = zero_or_bypass(rd_req[p], w_is_zero, w_hit);

    // Pick the next word for this port from the priority-resolved source.
    always_comb begin
      w_next = r_data;
      unique case (w_sel)
        SelZero:   w_next = '0;
        SelBypass: w_next = wr_data;
        SelRegs:   w_next = w_mux_data;
        default:   w_next = r_data;
      endcase
    end

    // Output flops: stall freezes data and valid; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_data  <= w_next;
        r_valid <= rd_req[p];
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = r_data;
    assign rd_valid[p]               = r_valid;
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed cases plus a randomised scoreboard sweep.
module tb_regfile_read_port;

  localparam int unsigned W  = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned NP = 3;
  localparam int unsigned AW = 5;
  localparam int unsigned ZR = 31;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR*W-1:0]   regs;
  logic [NP-1:0]     rd_req;
  logic [NP*AW-1:0]  rd_addr;
  logic              stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [W-1:0]      wr_data;
  logic [NP*W-1:0]   rd_data;
  logic [NP-1:0]     rd_valid;

  regfile_read_port #(
    .WIDTH    (W),
    .NREGS    (NR),
    .NPORTS   (NP),
    .ZERO_REG (ZR)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .regs     (regs),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .stall    (stall),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NP-1:0]   valid;
    logic [NP*W-1:0] data;
  } exp_t;

  exp_t            sb_q[$];
  logic [NP*W-1:0] m_data;
  logic [NP-1:0]   m_valid;
  int              n_vec = 0;
  int              n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_reg(input int r, input logic [W-1:0] v);
    regs[r*W +: W] = v;
  endtask

  task automatic set_addr(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Reference model: one expected snapshot per rising edge out of reset.
  always @(posedge clk or negedge reset_n) begin : b_model
    exp_t e;
    int   a;
    if (!reset_n) begin
      m_data  <= '0;
      m_valid <= '0;
      sb_q.delete();
    end else begin
      e.data  = m_data;
      e.valid = m_valid;
      if (!stall) begin
        for (int p = 0; p < NP; p++) begin
          e.valid[p] = rd_req[p];
          if (rd_req[p]) begin
            a = int'(rd_addr[p*AW +: AW]);
            if (a == ZR) e.data[p*W +: W] = '0;
            else if (wr_en && (int'(wr_addr) == a)) e.data[p*W +: W] = wr_data;
            else e.data[p*W +: W] = regs[a*W +: W];
          end
        end
      end
      sb_q.push_back(e);
      m_data  <= e.data;
      m_valid <= e.valid;
    end
  end

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin : b_check
    exp_t e;
    if (reset_n && (sb_q.size() > 0)) begin
      e = sb_q.pop_front();
      check_eq("sb_valid", 128'(rd_valid), 128'(e.valid));
      check_eq("sb_data", 128'(rd_data), 128'(e.data));
    end
  end

  initial begin
    reset_n = 1'b0;
    regs    = '0;
    rd_req  = '0;
    rd_addr = '0;
    stall   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    check_eq("por_valid", 128'(rd_valid), 128'(0));
    check_eq("por_data", 128'(rd_data), 128'(0));
    reset_n = 1'b1;

    // Plain read on two ports.
    set_reg(5, 32'hDEAD_BEEF);
    set_reg(7, 32'h0000_1234);
    set_addr(0, 5);
    set_addr(1, 7);
    rd_req = 3'b011;
    @(negedge clk);
    check_eq("plain_d0", 128'(rd_data[0*W +: W]), 128'(32'hDEAD_BEEF));
    check_eq("plain_d1", 128'(rd_data[1*W +: W]), 128'(32'h0000_1234));
    check_eq("plain_valid", 128'(rd_valid), 128'(3'b011));

    // Bypass wins over storage; a second port on the same index sees the same word.
    set_reg(3, 32'h0000_AAAA);
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h0000_5555;
    set_addr(0, 3);
    set_addr(2, 3);
    rd_req = 3'b101;
    @(negedge clk);
    check_eq("bypass_d0", 128'(rd_data[0*W +: W]), 128'(32'h0000_5555));
    check_eq("bypass_d2", 128'(rd_data[2*W +: W]), 128'(32'h0000_5555));
    check_eq("bypass_hold_d1", 128'(rd_data[1*W +: W]), 128'(32'h0000_1234));

    // Zero register ignores both storage and a write aimed at it.
    set_reg(31, 32'h0000_FFFF);
    wr_addr = 5'd31;
    wr_data = 32'h0000_7777;
    set_addr(1, 31);
    rd_req = 3'b011;
    @(negedge clk);
    check_eq("xzr_d1", 128'(rd_data[1*W +: W]), 128'(0));
    check_eq("xzr_wr_d0", 128'(rd_data[0*W +: W]), 128'(32'h0000_AAAA));

    // No request: data holds, valid drops.
    rd_req = 3'b000;
    wr_en  = 1'b0;
    @(negedge clk);
    check_eq("idle_d0", 128'(rd_data[0*W +: W]), 128'(32'h0000_AAAA));
    check_eq("idle_valid", 128'(rd_valid), 128'(0));

    // Stall freezes outputs while the address moves.
    set_reg(6, 32'h0000_CAFE);
    set_addr(0, 5);
    rd_req = 3'b001;
    @(negedge clk);
    check_eq("pre_stall_d0", 128'(rd_data[0*W +: W]), 128'(32'hDEAD_BEEF));
    set_addr(0, 6);
    stall  = 1'b1;
    rd_req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_d0", 128'(rd_data[0*W +: W]), 128'(32'hDEAD_BEEF));
      check_eq("stall_valid", 128'(rd_valid), 128'(3'b001));
    end
    stall  = 1'b0;
    rd_req = 3'b001;
    @(negedge clk);
    check_eq("post_stall_d0", 128'(rd_data[0*W +: W]), 128'(32'h0000_CAFE));

    // Asynchronous reset in the middle of a read.
    set_addr(1, 7);
    set_addr(2, 5);
    rd_req = 3'b111;
    @(negedge clk);
    check_eq("prereset_valid", 128'(rd_valid), 128'(3'b111));
    #2 reset_n = 1'b0;
    #1;
    check_eq("areset_valid", 128'(rd_valid), 128'(0));
    check_eq("areset_data", 128'(rd_data), 128'(0));
    @(negedge clk);
    rd_req  = 3'b000;
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("noreplay_valid", 128'(rd_valid), 128'(0));
    check_eq("noreplay_data", 128'(rd_data), 128'(0));

    // Random sweep checked by the scoreboard on every edge.
    for (int i = 0; i < 10000; i++) begin
      stall   = ($urandom_range(0, 4) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, NR - 1));
      wr_data = $urandom;
      rd_req  = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) set_addr(p, int'(wr_addr));
        else if ($urandom_range(0, 7) == 0) set_addr(p, ZR);
        else set_addr(p, int'($urandom_range(0, NR - 1)));
      end
      if ($urandom_range(0, 1) == 0) set_reg(int'($urandom_range(0, NR - 1)), $urandom);
      @(negedge clk);
    end
    stall  = 1'b0;
    rd_req = '0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
